stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
Hardware operand stack for the multicycle stack CPU. It is the downstream consumer of the control unit's push, pop and stack_src strobes.
- Selects push data from the ALU result or the MDR.
- Holds up to DEPTH entries.
- Exposes the top-of-stack combinationally, for operand loads and the jz zero test.
- Reports full/empty status and sticky overflow/underflow error flags.

Parameters:
WIDTH, 8, data width of each stack entry and of tos
DEPTH, 8, number of entries (legal range 2..64)
CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
push  input  1  push strobe from control unit
pop  input  1  pop strobe from control unit
stack_src  input  1  push data select: 0 = alu_result, 1 = mdr_data
alu_result  input  WIDTH  ALU output
mdr_data  input  WIDTH  memory data register output
clear_err  input  1  synchronous clear of the sticky error flags
tos  output  WIDTH  current top-of-stack; 0 when empty
count  output  CW  number of valid entries
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: a push was rejected because the stack was full
underflow  output  1  sticky: a pop was rejected because the stack was empty

Behaviour:
- Storage and pointer
  - Storage is a DEPTH x WIDTH register array plus a stack pointer sp (0..DEPTH) equal to count.
  - The entry at index sp-1 is the top.
- Reset (asynchronous, takes effect immediately)
  - sp = 0, overflow = 0, underflow = 0.
  - Outputs therefore read tos = 0, count = 0, empty = 1, full = 0.
  - Array contents are not reset and are unobservable while not valid.
  - Reset mid-operation discards all entries. A push/pop strobe coincident with reset deassertion is ignored in that cycle.
- Outputs are combinational from the state:
  - tos = empty ? 0 : array[sp-1].
  - empty and full are derived from sp.
  - No read latency: tos in the cycle a pop is asserted is the value being popped, so the datapath latches it on the same edge.
- Push data: din = stack_src ? mdr_data : alu_result, sampled on the clock edge.
- Per-edge operation, in priority order:
  1. push=1, pop=0, not full: array[sp] <= din; sp <= sp+1.
  2. push=1, pop=0, full: no change to array or sp; overflow <= 1.
  3. push=0, pop=1, not empty: sp <= sp-1; array untouched.
  4. push=0, pop=1, empty: no change; underflow <= 1.
  5. push=1, pop=1, not empty: replace top, array[sp-1] <= din; sp unchanged; no error, even when full.
  6. push=1, pop=1, empty: treated as push only, array[0] <= din, sp <= 1; underflow <= 1.
  7. Neither strobe: hold.
- Error flags
  - Sticky until clear_err or reset.
  - clear_err=1 clears both flags on the edge.
  - If a new error event occurs on the same edge, that flag is set (set wins over clear).
- No other state machine: occupancy (sp) is the only control state; all transitions are as enumerated above.
- Width rules
  - sp arithmetic is CW bits; no wrap-around is permitted. Full and empty guards prevent sp exceeding DEPTH or going below 0.
  - din is exactly WIDTH bits; no extension.

Test Plan:
- After reset, push 0x11, 0x22, 0x33 with stack_src=0 via alu_result -> count=3, tos=0x33; three pops show tos 0x33, 0x22, 0x11 in the pop cycles, then empty=1, tos=0x00.
- Push 0xA5 with stack_src=1 and alu_result=0xFF -> tos=0xA5, confirming the MDR path is selected.
- Push DEPTH values 1..8, then push 0x99 -> full=1, count=8, tos=0x08, overflow=1; pop -> tos=0x07, overflow stays 1 until clear_err pulses.
- Pop when empty -> underflow=1, count=0. Then clear_err and a pop together on the same edge -> underflow remains 1 (set wins).
- With 0x10, 0x20 on the stack, push+pop with din=0x55 -> count=2, tos=0x55, next pop shows 0x10. Repeat at full -> count stays 8, no overflow.
- Push 3 entries, then assert reset asynchronously between clock edges -> count=0, empty=1, tos=0 without waiting for a clock edge; the first push after release lands at index 0.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: operand stack for the multicycle stack CPU.
//   Pushes a WIDTH-bit value selected from the ALU result or the MDR.
//   Holds up to DEPTH entries and pops them in LIFO order.
//   Reports full/empty status and sticky overflow/underflow error flags.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   push, pop              control-unit strobes (both together = replace top)
//   stack_src              push data select: 0 = alu_result, 1 = mdr_data
//   alu_result, mdr_data   push data candidates
//   clear_err              synchronous clear of the sticky error flags
//   tos                    top of stack, combinational; 0 when empty
//   count                  number of valid entries (equals sp)
//   empty, full            occupancy status, combinational from sp
//   overflow, underflow    sticky error flags, registered
module stack_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             stack_src,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mdr_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  // Status and top-of-stack are derived directly from the pointer: no read latency.
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == CW'(DEPTH));
  assign count   = sp_q;
  assign top_idx = AW'(sp_q - CW'(1));
  assign tos     = empty ? '0 : mem_q[top_idx];
  assign din     = stack_src ? mdr_data : alu_result;

  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Next-state decode of the push/pop strobes against the guards.
  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = AW'(sp_q);
    ovf_d  = ovf_q & ~clear_err;
    unf_d  = unf_q & ~clear_err;

    if (push && !pop) begin
      if (!full) begin
        wr_en = 1'b1;
        sp_d  = sp_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop && !push) begin
      if (!empty) begin
        sp_d = sp_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (push && pop) begin
      wr_en = 1'b1;
      if (!empty) begin
        // Replace top in place; occupancy unchanged, legal even when full.
        wr_idx = top_idx;
      end else begin
        // Nothing to pop: behaves as a push into slot 0 but flags underflow.
        wr_idx = '0;
        sp_d   = CW'(1);
        unf_d  = 1'b1;
      end
    end
  end

  // Control state: pointer and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage array; contents are meaningless while not covered by sp, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             push, pop, stack_src, clear_err;
  logic [WIDTH-1:0] alu_result, mdr_data;
  logic [WIDTH-1:0] tos;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .stack_src  (stack_src),
    .alu_result (alu_result),
    .mdr_data   (mdr_data),
    .clear_err  (clear_err),
    .tos        (tos),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push      = 1'b0;
    pop       = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] v);
    push = 1'b1; stack_src = 1'b0; alu_result = v; mdr_data = 8'h00;
    tick();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
  endtask

  task automatic do_replace(input logic [WIDTH-1:0] v);
    push = 1'b1; pop = 1'b1; stack_src = 1'b0; alu_result = v;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (!empty) do_pop();
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; stack_src = 1'b0; clear_err = 1'b0;
    alu_result = '0; mdr_data = '0;
    #1;
    chk("rst_tos", 32'(tos), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LIFO order through the ALU path
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    chk("lifo_count", 32'(count), 32'd3);
    chk("lifo_tos", 32'(tos), 32'h33);
    pop = 1'b1; #1; chk("pop1_tos", 32'(tos), 32'h33); tick();
    pop = 1'b1; #1; chk("pop2_tos", 32'(tos), 32'h22); tick();
    pop = 1'b1; #1; chk("pop3_tos", 32'(tos), 32'h11); tick();
    chk("lifo_empty", 32'(empty), 32'd1);
    chk("lifo_tos0", 32'(tos), 32'h00);

    // MDR source select
    push = 1'b1; stack_src = 1'b1; mdr_data = 8'hA5; alu_result = 8'hFF;
    tick();
    chk("mdr_tos", 32'(tos), 32'hA5);
    chk("mdr_count", 32'(count), 32'd1);
    do_pop();

    // Fill, overflow, sticky until clear
    for (int i = 1; i <= DEPTH; i++) do_push(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    do_push(8'h99);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_tos", 32'(tos), 32'h08);
    chk("ovf_flag", 32'(overflow), 32'd1);
    do_pop();
    chk("ovf_pop_tos", 32'(tos), 32'h07);
    chk("ovf_pop_full", 32'(full), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_err = 1'b1; tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_clr_count", 32'(count), 32'd7);
    drain();
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow, and set wins over clear
    do_pop();
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    clear_err = 1'b1; pop = 1'b1; tick();
    chk("unf_setwins", 32'(underflow), 32'd1);
    clear_err = 1'b1; tick();
    chk("unf_cleared", 32'(underflow), 32'd0);

    // Replace top
    do_push(8'h10); do_push(8'h20);
    do_replace(8'h55);
    chk("rep_count", 32'(count), 32'd2);
    chk("rep_tos", 32'(tos), 32'h55);
    do_pop();
    chk("rep_pop_tos", 32'(tos), 32'h10);
    drain();
    for (int i = 1; i <= DEPTH; i++) do_push(8'(i));
    do_replace(8'h77);
    chk("repf_count", 32'(count), 32'd8);
    chk("repf_tos", 32'(tos), 32'h77);
    chk("repf_full", 32'(full), 32'd1);
    chk("repf_ovf", 32'(overflow), 32'd0);
    do_pop();
    chk("repf_pop_tos", 32'(tos), 32'h07);
    drain();

    // Push+pop on empty: acts as push, flags underflow
    do_replace(8'h66);
    chk("repe_count", 32'(count), 32'd1);
    chk("repe_tos", 32'(tos), 32'h66);
    chk("repe_unf", 32'(underflow), 32'd1);
    clear_err = 1'b1; tick();
    drain();

    // Asynchronous reset between edges
    do_push(8'hC1); do_push(8'hC2); do_push(8'hC3);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2; reset = 1'b1; #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_tos", 32'(tos), 32'h00);
    #2; reset = 1'b0;
    do_push(8'h42);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_tos", 32'(tos), 32'h42);
    do_push(8'h43);
    do_pop();
    chk("post_rst_idx0", 32'(tos), 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
